// File: rtl/spad_acq_sched.sv
// Frame-level SPAD acquisition scheduler: arms the readout FSM once per frame and
// wraps each frame's data in header/trailer words; it is the only host FIFO writer.
module spad_acq_sched #(
  parameter logic [15:0] HDR_MAGIC  = 16'hFA5E,
  parameter logic [7:0]  TRL_TAG    = 8'hE0,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_frames,
  input  logic [1:0]  window_cfg,
  input  logic        pll_locked,
  output logic        fsm_en,
  output logic [1:0]  window_cycles,
  input  logic [15:0] fsm_dout,
  input  logic        fsm_wr,
  input  logic        fsm_done,
  output logic [15:0] fifo_din,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic        busy,
  output logic [15:0] frame_idx,
  output logic        overflow,
  output logic        lock_lost
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  // state | meaning: IDLE wait start | WAIT_LOCK wait pll | HDR0/HDR1 magic, frame index
  // RUN forward readout data | TRAILER tag + drop count | GAP inter-frame idle
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_HDR0, S_HDR1, S_RUN, S_TRAILER, S_GAP
  } state_t;

  state_t          r_state, w_state;
  logic [15:0]     r_num, w_num;
  logic [1:0]      r_win, w_win;
  logic [15:0]     r_idx, w_idx;
  logic [7:0]      r_drops, w_drops;
  logic            r_stop_pend, w_stop_pend;
  logic            r_ovf, w_ovf;
  logic            r_lock, w_lock;
  logic            r_en, w_en;
  logic [15:0]     r_din, w_din;
  logic            r_wr, w_wr;
  logic [GW-1:0]   r_gap, w_gap;
  logic            r_busy, w_busy;
  logic [15:0]     w_idx_inc;
  logic            w_stop_any;
  logic            w_last;

  assign w_idx_inc  = r_idx + 16'd1;
  assign w_stop_any = r_stop_pend | stop;
  assign w_last     = (r_num != 16'd0) && (w_idx_inc == r_num);

  always_comb begin
    w_state     = r_state;
    w_num       = r_num;
    w_win       = r_win;
    w_idx       = r_idx;
    w_drops     = r_drops;
    w_stop_pend = r_stop_pend;
    w_ovf       = r_ovf;
    w_lock      = r_lock;
    w_din       = r_din;
    w_wr        = 1'b0;
    w_gap       = r_gap;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_win   = window_cfg;
          w_num   = num_frames;
          w_idx   = '0;
          w_ovf   = 1'b0;
          w_lock  = 1'b0;
          w_state = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (stop)            w_state = S_IDLE;
        else if (pll_locked) w_state = S_HDR0;
      end
      S_HDR0: begin
        if (stop) w_stop_pend = 1'b1;
        if (!fifo_full) begin
          w_wr    = 1'b1;
          w_din   = HDR_MAGIC;
          w_state = S_HDR1;
        end
      end
      S_HDR1: begin
        if (stop) w_stop_pend = 1'b1;
        if (!fifo_full) begin
          w_wr    = 1'b1;
          w_din   = r_idx;
          w_state = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) w_stop_pend = 1'b1;
        // The readout FSM cannot stall, so a word that meets a full FIFO is lost.
        if (fsm_wr) begin
          if (!fifo_full) begin
            w_wr  = 1'b1;
            w_din = fsm_dout;
          end else begin
            w_ovf = 1'b1;
            if (r_drops != 8'hFF) w_drops = r_drops + 8'd1;
          end
        end
        if (!pll_locked) begin
          w_lock  = 1'b1;
          w_state = S_TRAILER;
        end else if (fsm_done) begin
          w_state = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (stop) w_stop_pend = 1'b1;
        if (!fifo_full) begin
          w_wr    = 1'b1;
          w_din   = {TRL_TAG, r_drops};
          w_drops = '0;
          if (w_stop_any || r_lock || w_last) begin
            w_state = S_IDLE;
          end else begin
            w_idx   = w_idx_inc;
            w_gap   = GAP_LOAD;
            w_state = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (stop) w_stop_pend = 1'b1;
        if (r_gap == '0) begin
          if (w_stop_any)      w_state = S_IDLE;
          else if (pll_locked) w_state = S_HDR0;
          else                 w_state = S_WAIT_LOCK;
        end else begin
          w_gap = r_gap - GW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
    if (w_state == S_IDLE) w_stop_pend = 1'b0;
  end

  // fsm_en is withheld on the RUN entry cycle and drops on the cycle RUN is left.
  assign w_en   = (r_state == S_RUN) && (w_state == S_RUN);
  assign w_busy = (w_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_win       <= '0;
      r_idx       <= '0;
      r_drops     <= '0;
      r_stop_pend <= 1'b0;
      r_ovf       <= 1'b0;
      r_lock      <= 1'b0;
      r_en        <= 1'b0;
      r_din       <= '0;
      r_wr        <= 1'b0;
      r_gap       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_num       <= w_num;
      r_win       <= w_win;
      r_idx       <= w_idx;
      r_drops     <= w_drops;
      r_stop_pend <= w_stop_pend;
      r_ovf       <= w_ovf;
      r_lock      <= w_lock;
      r_en        <= w_en;
      r_din       <= w_din;
      r_wr        <= w_wr;
      r_gap       <= w_gap;
      r_busy      <= w_busy;
    end
  end

  assign fsm_en        = r_en;
  assign window_cycles = r_win;
  assign fifo_din      = r_din;
  assign fifo_wr       = r_wr;
  assign busy          = r_busy;
  assign frame_idx     = r_idx;
  assign overflow      = r_ovf;
  assign lock_lost     = r_lock;
endmodule

// File: tb/tb_spad_acq_sched.sv
// Bench for spad_acq_sched: emulates the readout FSM and host FIFO, and checks the
// FIFO word stream against a frame-level model built from the framing rules.
module tb_spad_acq_sched;
  logic        clk = 1'b0;
  logic        rst, start, stop, pll_locked, fsm_wr, fsm_done, fifo_full;
  logic [15:0] num_frames, fsm_dout;
  logic [1:0]  window_cfg;
  logic        fsm_en, fifo_wr, busy, overflow, lock_lost;
  logic [1:0]  window_cycles;
  logic [15:0] fifo_din, frame_idx;

  spad_acq_sched dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_frames(num_frames),
    .window_cfg(window_cfg), .pll_locked(pll_locked), .fsm_en(fsm_en),
    .window_cycles(window_cycles), .fsm_dout(fsm_dout), .fsm_wr(fsm_wr),
    .fsm_done(fsm_done), .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_full(fifo_full),
    .busy(busy), .frame_idx(frame_idx), .overflow(overflow), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] cap[$];
  int          cap_cyc[$];
  logic [15:0] exp_q[$];
  logic [1:0]  exp_win = 2'b00;
  int          win_err = 0;
  int          en_err = 0;
  int          drops;
  int          tot_drops;

  always @(posedge clk) cyc <= cyc + 1;

  // Host-side FIFO capture plus continuous invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      cap.push_back(fifo_din);
      cap_cyc.push_back(cyc);
    end
    if (busy === 1'b1 && window_cycles !== exp_win) win_err <= win_err + 1;
    if (busy === 1'b0 && fsm_en === 1'b1) en_err <= en_err + 1;
  end

  typedef struct {
    logic [15:0] nf;
    logic [1:0]  win;
    int          nw;
    logic [31:0] fmask;
    int          exp_len;
    logic [15:0] exp_trl;
    logic        exp_ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_acq(input logic [15:0] nf, input logic [1:0] win);
    num_frames = nf;
    window_cfg = win;
    exp_win    = win;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    window_cfg = ~win;
    num_frames = 16'($urandom);
  endtask

  task automatic wait_en();
    int n = 0;
    while (fsm_en !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("wait_fsm_en", {31'd0, fsm_en}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 600) begin
      tick();
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic model_header(input int idx);
    exp_q.push_back(16'hFA5E);
    exp_q.push_back(16'(idx));
    drops = 0;
  endtask

  task automatic feed_words(input int nw, input logic [31:0] fmask, input bit rnd);
    for (int i = 0; i < nw; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        fsm_wr    = 1'b0;
        fifo_full = 1'b0;
        tick();
      end
      fsm_wr    = 1'b1;
      fsm_dout  = 16'($urandom);
      fifo_full = rnd ? ($urandom_range(0, 3) == 0) : fmask[(i < 32) ? i : 31];
      if (fifo_full) begin
        drops++;
        tot_drops++;
      end else begin
        exp_q.push_back(fsm_dout);
      end
      tick();
    end
    fsm_wr    = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic finish_frame();
    fsm_done = 1'b1;
    tick();
    fsm_done = 1'b0;
    exp_q.push_back({8'hE0, (drops > 255) ? 8'hFF : 8'(drops)});
  endtask

  task automatic compare_stream(input string name, input int base);
    check({name, "_len"}, cap.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < cap.size(); i++)
      check($sformatf("%s_w%0d", name, i), {16'd0, cap[base + i]}, {16'd0, exp_q[i]});
  endtask

  task automatic run_acq(input string name, input logic [15:0] nf, input logic [1:0] win,
                         input int nw, input logic [31:0] fmask, input bit rnd,
                         output int base);
    int w0, e0, k;
    base = cap.size();
    w0 = win_err;
    e0 = en_err;
    tot_drops = 0;
    exp_q.delete();
    start_acq(nf, win);
    for (int f = 0; f < int'(nf); f++) begin
      wait_en();
      model_header(f);
      k = rnd ? $urandom_range(0, 12) : nw;
      feed_words(k, fmask, rnd);
      finish_frame();
    end
    wait_idle();
    compare_stream(name, base);
    check({name, "_win_stable"}, win_err - w0, 0);
    check({name, "_en_outside"}, en_err - e0, 0);
    check({name, "_ovf"}, {31'd0, overflow}, {31'd0, tot_drops > 0});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   base, bad, w0;

    vt[0] = '{nf: 16'd2, win: 2'b10, nw: 3,   fmask: 32'h0,        exp_len: 12, exp_trl: 16'hE000, exp_ovf: 1'b0};
    vt[1] = '{nf: 16'd1, win: 2'b01, nw: 10,  fmask: 32'h252,      exp_len: 9,  exp_trl: 16'hE004, exp_ovf: 1'b1};
    vt[2] = '{nf: 16'd3, win: 2'b11, nw: 1,   fmask: 32'h0,        exp_len: 12, exp_trl: 16'hE000, exp_ovf: 1'b0};
    vt[3] = '{nf: 16'd1, win: 2'b00, nw: 0,   fmask: 32'h0,        exp_len: 3,  exp_trl: 16'hE000, exp_ovf: 1'b0};
    vt[4] = '{nf: 16'd1, win: 2'b10, nw: 260, fmask: 32'hFFFFFFFF, exp_len: 3,  exp_trl: 16'hE0FF, exp_ovf: 1'b1};

    rst = 1'b1; start = 1'b0; stop = 1'b0; pll_locked = 1'b1; fsm_wr = 1'b0;
    fsm_done = 1'b0; fifo_full = 1'b0; num_frames = '0; fsm_dout = '0; window_cfg = '0;
    repeat (3) tick();
    check("rst_flags", {27'd0, busy, fsm_en, fifo_wr, overflow, lock_lost}, 32'd0);
    check("rst_win", {30'd0, window_cycles}, 32'd0);
    check("rst_idx_din", {frame_idx, fifo_din}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_acq($sformatf("vec%0d", i), vt[i].nf, vt[i].win, vt[i].nw, vt[i].fmask, 1'b0, base);
      check($sformatf("vec%0d_len_const", i), cap.size() - base, vt[i].exp_len);
      check($sformatf("vec%0d_trailer", i), {16'd0, cap[cap.size() - 1]}, {16'd0, vt[i].exp_trl});
      check($sformatf("vec%0d_ovf_const", i), {31'd0, overflow}, {31'd0, vt[i].exp_ovf});
      check($sformatf("vec%0d_frame_idx", i), {16'd0, frame_idx}, {16'd0, vt[i].nf - 16'd1});
      if (i == 0 && cap.size() >= base + 7)
        check("vec0_gap_cycles", cap_cyc[base + 6] - cap_cyc[base + 5], 9);
    end

    // Header stalls while the FIFO is full.
    base = cap.size();
    exp_q.delete();
    fifo_full = 1'b1;
    start_acq(1, 2'b01);
    bad = 0;
    repeat (7) begin
      tick();
      if (fifo_wr !== 1'b0 || fsm_en !== 1'b0) bad++;
    end
    check("hdr_stall_quiet", bad, 0);
    check("hdr_stall_busy", {31'd0, busy}, 32'd1);
    fifo_full = 1'b0;
    model_header(0);
    wait_en();
    feed_words(1, 32'h0, 1'b0);
    finish_frame();
    wait_idle();
    compare_stream("hdr_stall", base);

    // Continuous run stopped during the third frame's RUN.
    base = cap.size();
    exp_q.delete();
    start_acq(0, 2'b11);
    for (int f = 0; f < 3; f++) begin
      wait_en();
      model_header(f);
      if (f == 2) begin
        stop = 1'b1;
        feed_words(1, 32'h0, 1'b0);
        stop = 1'b0;
      end
      feed_words(2, 32'h0, 1'b0);
      finish_frame();
    end
    wait_idle();
    repeat (20) tick();
    compare_stream("stop_run", base);
    check("stop_run_busy", {31'd0, busy}, 32'd0);
    check("stop_run_idx", {16'd0, frame_idx}, 32'd2);

    // Stop arriving during the inter-frame gap: no further header.
    base = cap.size();
    exp_q.delete();
    start_acq(0, 2'b01);
    wait_en();
    model_header(0);
    feed_words(1, 32'h0, 1'b0);
    finish_frame();
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle();
    repeat (20) tick();
    compare_stream("stop_gap", base);

    // Lock loss in RUN ends the acquisition after a trailer.
    base = cap.size();
    exp_q.delete();
    start_acq(5, 2'b10);
    wait_en();
    model_header(0);
    feed_words(2, 32'h0, 1'b0);
    finish_frame();
    wait_en();
    model_header(1);
    feed_words(1, 32'h0, 1'b0);
    pll_locked = 1'b0;
    tick();
    check("lockloss_en_low", {31'd0, fsm_en}, 32'd0);
    exp_q.push_back(16'hE000);
    wait_idle();
    check("lockloss_sticky", {31'd0, lock_lost}, 32'd1);
    compare_stream("lockloss", base);

    // Start without lock waits, then stop in WAIT_LOCK exits cleanly.
    base = cap.size();
    start_acq(1, 2'b01);
    check("nolock_lock_cleared", {31'd0, lock_lost}, 32'd0);
    repeat (20) tick();
    check("nolock_busy", {31'd0, busy}, 32'd1);
    check("nolock_no_writes", cap.size() - base, 0);
    check("nolock_en", {31'd0, fsm_en}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("nolock_stop_idle", {31'd0, busy}, 32'd0);
    pll_locked = 1'b1;
    repeat (3) tick();
    check("nolock_no_writes2", cap.size() - base, 0);

    // Start while busy is ignored; data and done in the same cycle.
    base = cap.size();
    w0 = win_err;
    exp_q.delete();
    start_acq(2, 2'b00);
    wait_en();
    model_header(0);
    num_frames = 16'd7;
    window_cfg = 2'b11;
    start = 1'b1;
    feed_words(2, 32'h0, 1'b0);
    start = 1'b0;
    finish_frame();
    wait_en();
    model_header(1);
    fsm_wr = 1'b1;
    fsm_dout = 16'hBEEF;
    fsm_done = 1'b1;
    exp_q.push_back(16'hBEEF);
    tick();
    fsm_wr = 1'b0;
    fsm_done = 1'b0;
    exp_q.push_back(16'hE000);
    wait_idle();
    repeat (20) tick();
    compare_stream("wr_done", base);
    check("start_busy_win", win_err - w0, 0);

    // Reset in RUN clears everything with no trailer.
    start_acq(1, 2'b11);
    wait_en();
    base = cap.size();
    fsm_wr = 1'b1;
    fsm_dout = 16'h1234;
    fifo_full = 1'b1;
    tick();
    fsm_wr = 1'b0;
    fifo_full = 1'b0;
    check("prerst_ovf", {31'd0, overflow}, 32'd1);
    rst = 1'b1;
    tick();
    check("runrst_flags", {27'd0, busy, fsm_en, fifo_wr, overflow, lock_lost}, 32'd0);
    check("runrst_win_idx", {14'd0, window_cycles, frame_idx}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("runrst_no_trailer", cap.size() - base, 0);
    check("runrst_idle", {31'd0, busy}, 32'd0);

    // Randomized acquisitions against the frame model.
    for (int r = 0; r < 25; r++)
      run_acq($sformatf("rnd%0d", r), 16'($urandom_range(1, 3)), 2'($urandom), 0, 32'h0,
              1'b1, base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spad_acq_sched.md
Name: spad_acq_sched

Overview:
- Frame-level acquisition scheduler that sits above the SPAD pixel readout FSM.
- Arms the readout FSM for a programmed number of frames and holds `window_cycles` stable for the whole acquisition.
- Frames each readout with header and trailer words, and is the single writer of the 16-bit host FIFO.
- The readout FSM cannot stall, so FIFO-full during readout drops data; drops are counted and flagged.

Parameters:
- HDR_MAGIC, 16'hFA5E, first header word of every frame.
- TRL_TAG, 8'hE0, upper byte of the trailer word.
- GAP_CYCLES, 8, idle clk cycles between frames (minimum 1).

Ports:
- clk  in  1  system clock (80 MHz domain)
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins an acquisition
- stop  in  1  one-cycle pulse; ends the acquisition after the current frame
- num_frames  in  16  frames per acquisition; 0 = continuous until stop
- window_cfg  in  2  requested photon-gathering windows per frame
- pll_locked  in  1  laser PLL lock
- fsm_en  out  1  enable to the readout FSM
- window_cycles  out  2  window count to the readout FSM, latched at start
- fsm_dout  in  16  readout FSM data word
- fsm_wr  in  1  readout FSM write strobe
- fsm_done  in  1  one-cycle pulse; readout FSM finished a frame
- fifo_din  out  16  FIFO write data
- fifo_wr  out  1  FIFO write enable
- fifo_full  in  1  FIFO full
- busy  out  1  high in every state except IDLE
- frame_idx  out  16  index of the current frame
- overflow  out  1  sticky: at least one word dropped
- lock_lost  out  1  sticky: PLL lost lock during RUN

Behaviour:
Reset:
- All outputs are 0, state is IDLE, internal counters are 0.
- Reset mid-operation aborts immediately; no trailer is written.

Outputs and latency:
- All outputs are registered.
- fifo_wr/fifo_din appear 1 cycle after the accepting condition.
- At most one FIFO write per cycle.

States:
- IDLE: on start, latch window_cfg into window_cycles and num_frames into an internal register. Clear overflow, lock_lost and frame_idx. Go to WAIT_LOCK. start in any other state is ignored.
- WAIT_LOCK: wait for pll_locked=1, then go to HDR0. stop here goes to IDLE without writing anything.
- HDR0: when !fifo_full, write HDR_MAGIC and go to HDR1. While full, hold.
- HDR1: when !fifo_full, write frame_idx and go to RUN.
- RUN:
  - fsm_en=1 from the cycle after entry.
  - fsm_wr & !fifo_full: forward fsm_dout.
  - fsm_wr & fifo_full: drop the word, set overflow, and increment the per-frame drop counter (8-bit, saturates at 255).
  - fsm_done: fsm_en=0 next cycle, go to TRAILER. If fsm_wr and fsm_done arrive in the same cycle, the data word is handled first, then the trailer is written.
  - pll_locked=0: set lock_lost, fsm_en=0 next cycle, go to TRAILER, and end the acquisition after the trailer.
- TRAILER:
  - When !fifo_full, write {TRL_TAG, frame_drops} and clear frame_drops.
  - fsm_wr in this state is ignored and not counted.
  - The acquisition ends if any of: stop_pending, lock_lost, or (num_frames≠0 and frame_idx+1 == num_frames). Ending goes to IDLE.
  - Otherwise frame_idx increments (wraps 16'hFFFF→0) and the state goes to GAP.
- GAP: count GAP_CYCLES clk cycles. If pll_locked, go to HDR0; else go to WAIT_LOCK.

stop handling:
- stop in HDR0, HDR1, RUN, TRAILER or GAP sets stop_pending.
- In GAP it goes to IDLE at the end of the gap without a new header.
- stop_pending clears on entering IDLE.

Other rules:
- window_cycles never changes while busy.
- fsm_en is never high outside RUN.
- The header and trailer are never dropped; those states stall on fifo_full.

Test Plan:
- Basic 2-frame run: num_frames=2, window_cfg=2'b10, pll_locked=1, fifo_full=0, 3 fsm_wr words then fsm_done per frame → FIFO sequence FA5E,0000,d0,d1,d2,E000,FA5E,0001,d0,d1,d2,E000; busy falls after the second trailer; window_cycles=2'b10 throughout.
- Backpressure: fifo_full=1 during 4 of 10 fsm_wr cycles → 6 words written, overflow=1, trailer=E004.
- Header stall: fifo_full=1 in HDR0 for 5 cycles → no write and fsm_en=0 until full clears, then FA5E written.
- stop mid-frame with num_frames=0: stop during RUN of frame 3 → frame 3 completes with its trailer, no frame 4 header, busy=0.
- Lock loss: pll_locked drops in RUN → fsm_en low next cycle, trailer written, lock_lost=1, IDLE. Also start with pll_locked=0 → stays in WAIT_LOCK with no FIFO writes.
- Edge cases: fsm_wr and fsm_done in the same cycle → data word precedes the trailer. rst asserted in RUN → all outputs 0 next cycle. start while busy → ignored.
